// File: rtl/riscv_alu_mdu_if.sv
// Request/response bundle for the integer ALU + iterative multiply/divide unit.
interface riscv_alu_mdu_if #(parameter int XLEN = 32);
  logic            i_valid;
  logic            o_ready;
  logic            i_flush;
  logic [XLEN-1:0] i_alu_a;
  logic [XLEN-1:0] i_alu_b;
  logic [4:0]      i_alu_ctrl;
  logic            o_valid;
  logic [XLEN-1:0] o_alu_out;
  logic            o_illegal;

  modport master (
    output i_valid, i_flush, i_alu_a, i_alu_b, i_alu_ctrl,
    input  o_ready, o_valid, o_alu_out, o_illegal
  );
  modport slave (
    input  i_valid, i_flush, i_alu_a, i_alu_b, i_alu_ctrl,
    output o_ready, o_valid, o_alu_out, o_illegal
  );
endinterface

// File: rtl/riscv_alu_mdu.sv
// RV32/64 integer ALU with M-extension: single-cycle ALU ops, XLEN-cycle
// shift-add multiply and restoring divide on magnitudes with final sign fix-up.
module riscv_alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic            i_clk,
  input logic            i_rst,
  riscv_alu_mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_XOR = 5'd2,  OP_OR = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [4:0]      op;
  logic [XLEN-1:0] hi, lo, mcand;
  logic            neg_q, neg_r;
  logic            ready_q, valid_q, illegal_q;
  logic [XLEN-1:0] out_q;

  logic [XLEN-1:0] a, b;
  logic [4:0]      ctrl;
  logic [SHW-1:0]  shamt;
  logic            accept;
  assign a      = bus.i_alu_a;
  assign b      = bus.i_alu_b;
  assign ctrl   = bus.i_alu_ctrl;
  assign shamt  = b[SHW-1:0];
  assign accept = bus.i_valid && ready_q && !bus.i_flush;

  // Operand decode at acceptance
  logic            is_mul, is_div, a_sgn, b_sgn, sa, sb, div_zero, div_ovf, multi;
  logic [XLEN-1:0] mag_a, mag_b;
  always_comb begin
    is_mul   = ctrl inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    is_div   = ctrl inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    a_sgn    = ctrl inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn    = ctrl inside {OP_MULH, OP_DIV, OP_REM};
    sa       = a_sgn & a[XLEN-1];
    sb       = b_sgn & b[XLEN-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = (ctrl == OP_DIV || ctrl == OP_REM) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    multi    = (is_mul || is_div) && !div_zero && !div_ovf;
  end

  // Single-cycle results, including the division special cases
  logic [XLEN-1:0] quick;
  logic            quick_ill;
  always_comb begin
    quick     = '0;
    quick_ill = (ctrl > OP_REMU);
    case (ctrl)
      OP_ADD:          quick = a + b;
      OP_SUB:          quick = a - b;
      OP_XOR:          quick = a ^ b;
      OP_OR:           quick = a | b;
      OP_AND:          quick = a & b;
      OP_SLL:          quick = a << shamt;
      OP_SRL:          quick = a >> shamt;
      OP_SRA:          quick = $signed(a) >>> shamt;
      OP_SLT:          quick = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:         quick = {{(XLEN-1){1'b0}}, a < b};
      OP_DIV, OP_DIVU: quick = div_zero ? '1 : a;
      OP_REM, OP_REMU: quick = div_zero ? a : '0;
      default:         quick = '0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on {hi,lo}
  logic            op_mul;
  logic [XLEN:0]   msum, dshift, ddiff;
  logic            dok;
  logic [XLEN-1:0] hi_n, lo_n;
  always_comb begin
    op_mul = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    msum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    dshift = {hi, lo[XLEN-1]};
    ddiff  = dshift - {1'b0, mcand};
    dok    = !ddiff[XLEN];
    if (op_mul) begin
      hi_n = msum[XLEN:1];
      lo_n = {msum[0], lo[XLEN-1:1]};
    end else begin
      hi_n = dok ? ddiff[XLEN-1:0] : dshift[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], dok};
    end
  end

  // Sign correction applied to the value produced by the last iteration
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   q_s, r_s, fin;
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -lo_n : lo_n;
    r_s    = neg_r ? -hi_n : hi_n;
    case (op)
      OP_MUL:                        fin = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin = q_s;
      default:                       fin = r_s;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      out_q     <= '0;
    end else if (bus.i_flush) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        cnt   <= '0;
        op    <= ctrl;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        if (multi) begin
          state   <= CALC;
          ready_q <= 1'b0;
          hi      <= '0;
          lo      <= is_mul ? mag_b : mag_a;
          mcand   <= is_mul ? mag_a : mag_b;
        end else begin
          state     <= DONE;
          ready_q   <= 1'b1;
          valid_q   <= 1'b1;
          out_q     <= quick;
          illegal_q <= quick_ill;
        end
      end else if (state == CALC) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(XLEN-1)) begin
          state     <= DONE;
          ready_q   <= 1'b1;
          valid_q   <= 1'b1;
          out_q     <= fin;
          illegal_q <= 1'b0;
        end
      end else begin
        state   <= IDLE;
        ready_q <= 1'b1;
      end
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_alu_out = out_q;
  assign bus.o_illegal = illegal_q;
endmodule

// File: tb/tb_riscv_alu_mdu.sv
// Directed-vector bench for riscv_alu_mdu at XLEN=32 and XLEN=64.
module tb_riscv_alu_mdu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  riscv_alu_mdu_if #(.XLEN(32)) b32();
  riscv_alu_mdu_if #(.XLEN(64)) b64();

  riscv_alu_mdu #(.XLEN(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(b32));
  riscv_alu_mdu #(.XLEN(64)) dut64 (.i_clk(clk), .i_rst(rst), .bus(b64));

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, XOR_ = 5'd2, OR_ = 5'd3, AND_ = 5'd4;
  localparam logic [4:0] SLL = 5'd5, SRL = 5'd6, SRA = 5'd7, SLT = 5'd8, SLTU = 5'd9;
  localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13;
  localparam logic [4:0] DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input logic [4:0] c, input logic [63:0] a,
                       input logic [63:0] b, input logic v);
    if (w) begin
      b64.i_valid = v; b64.i_alu_ctrl = c; b64.i_alu_a = a; b64.i_alu_b = b;
    end else begin
      b32.i_valid = v; b32.i_alu_ctrl = c; b32.i_alu_a = a[31:0]; b32.i_alu_b = b[31:0];
    end
  endtask

  function automatic logic get_valid(input bit w);
    return w ? b64.o_valid : b32.o_valid;
  endfunction
  function automatic logic [63:0] get_out(input bit w);
    return w ? b64.o_alu_out : {32'd0, b32.o_alu_out};
  endfunction
  function automatic logic get_ill(input bit w);
    return w ? b64.o_illegal : b32.o_illegal;
  endfunction

  // Issue one op, scramble the inputs right after acceptance, measure latency.
  task automatic run(input string tag, input bit w, input logic [4:0] c,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int lat, input logic ill);
    int n;
    @(negedge clk); drive(w, c, a, b, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(w, 5'd31, ~a, ~b, 1'b0);
    n = 1;
    while (!get_valid(w) && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_out"}, get_out(w), exp);
    chk({tag, "_ill"}, {63'd0, get_ill(w)}, {63'd0, ill});
    @(negedge clk);
    chk({tag, "_pulse"}, {63'd0, get_valid(w)}, 64'd0);
  endtask

  task automatic count_pulses(input string tag, input int cycles);
    int p;
    p = 0;
    repeat (cycles) begin @(negedge clk); if (b32.o_valid) p++; end
    chk(tag, 64'(p), 64'd0);
  endtask

  initial begin
    int n;
    drive(0, 5'd0, 64'd0, 64'd0, 1'b0);
    drive(1, 5'd0, 64'd0, 64'd0, 1'b0);
    b32.i_flush = 1'b0;
    b64.i_flush = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, b32.o_ready}, 64'd0);
    chk("rst_valid", {63'd0, b32.o_valid}, 64'd0);
    chk("rst_out",   get_out(0), 64'd0);
    chk("rst_ill",   {63'd0, b32.o_illegal}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", {63'd0, b32.o_ready}, 64'd1);

    run("add_wrap", 0, ADD,  64'hFFFFFFFF, 64'h1,        64'h0,        1, 1'b0);
    run("sra",      0, SRA,  64'h80000000, 64'h24,       64'hF8000000, 1, 1'b0);
    run("sub",      0, SUB,  64'h5,        64'h7,        64'hFFFFFFFE, 1, 1'b0);
    run("sll",      0, SLL,  64'h1,        64'h3F,       64'h80000000, 1, 1'b0);
    run("srl",      0, SRL,  64'h80000000, 64'h1F,       64'h1,        1, 1'b0);
    run("xor",      0, XOR_, 64'hF0F0F0F0, 64'hFF00FF00, 64'h0FF00FF0, 1, 1'b0);
    run("or",       0, OR_,  64'hF0000000, 64'h0000000F, 64'hF000000F, 1, 1'b0);
    run("and",      0, AND_, 64'hF0F0F0F0, 64'hFF00FF00, 64'hF000F000, 1, 1'b0);
    run("slt",      0, SLT,  64'hFFFFFFFF, 64'h1,        64'h1,        1, 1'b0);
    run("sltu",     0, SLTU, 64'hFFFFFFFF, 64'h1,        64'h0,        1, 1'b0);
    run("illegal",  0, 5'd20, 64'h3,       64'h4,        64'h0,        1, 1'b1);

    run("mulh",     0, MULH,   64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0,        33, 1'b0);
    run("mulhu",    0, MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33, 1'b0);
    run("mulhsu",   0, MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33, 1'b0);
    run("mul_neg",  0, MUL,    64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 33, 1'b0);

    run("div",      0, DIV,  64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 33, 1'b0);
    run("rem",      0, REM,  64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 33, 1'b0);
    run("divu_z",   0, DIVU, 64'h5,        64'h0,        64'hFFFFFFFF, 1,  1'b0);
    run("remu_z",   0, REMU, 64'h5,        64'h0,        64'h5,        1,  1'b0);
    run("rem_ovf",  0, REM,  64'h80000000, 64'hFFFFFFFF, 64'h0,        1,  1'b0);
    run("div_ovf",  0, DIV,  64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1,  1'b0);
    run("remu",     0, REMU, 64'd100,      64'd7,        64'd2,        33, 1'b0);
    run("divu",     0, DIVU, 64'd100,      64'd7,        64'd14,       33, 1'b0);

    // Flush mid-divide: no result, output held, ready back next edge
    @(negedge clk); drive(0, DIVU, 64'd200, 64'd3, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(0, 5'd31, 64'd0, 64'd0, 1'b0);
    repeat (8) @(negedge clk);
    b32.i_flush = 1'b1;
    @(negedge clk);
    b32.i_flush = 1'b0;
    chk("flush_ready", {63'd0, b32.o_ready}, 64'd1);
    chk("flush_valid", {63'd0, b32.o_valid}, 64'd0);
    chk("flush_out",   get_out(0), 64'd14);
    count_pulses("flush_no_result", 40);

    // Request coinciding with flush in IDLE is dropped
    @(negedge clk); b32.i_flush = 1'b1; drive(0, ADD, 64'd1, 64'd1, 1'b1);
    @(negedge clk); b32.i_flush = 1'b0; drive(0, ADD, 64'd0, 64'd0, 1'b0);
    chk("flush_drop_valid", {63'd0, b32.o_valid}, 64'd0);
    chk("flush_drop_out",   get_out(0), 64'd14);
    count_pulses("flush_drop_none", 3);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk); drive(0, MUL, 64'd3, 64'd5, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(0, 5'd31, 64'd0, 64'd0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out",   get_out(0), 64'd0);
    chk("midrst_ready", {63'd0, b32.o_ready}, 64'd0);
    chk("midrst_valid", {63'd0, b32.o_valid}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", {63'd0, b32.o_ready}, 64'd1);
    count_pulses("midrst_no_result", 40);

    // Back-to-back: ADD accepted in the DONE cycle of a MUL
    @(negedge clk); drive(0, MUL, 64'd3, 64'd4, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(0, 5'd31, 64'd0, 64'd0, 1'b0);
    n = 1;
    while (!b32.o_valid && n < 200) begin @(negedge clk); n++; end
    chk("b2b_mul_lat", 64'(n), 64'd33);
    chk("b2b_mul_out", get_out(0), 64'd12);
    chk("b2b_ready_done", {63'd0, b32.o_ready}, 64'd1);
    drive(0, ADD, 64'd2, 64'd3, 1'b1);
    @(negedge clk); drive(0, 5'd31, 64'd0, 64'd0, 1'b0);
    chk("b2b_add_valid", {63'd0, b32.o_valid}, 64'd1);
    chk("b2b_add_out",   get_out(0), 64'd5);
    @(negedge clk);
    chk("b2b_end", {63'd0, b32.o_valid}, 64'd0);

    run("w64_mulhu", 1, MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
        64'hFFFFFFFFFFFFFFFE, 65, 1'b0);
    run("w64_sll",   1, SLL, 64'h1, 64'h41, 64'h2, 1, 1'b0);
    run("w64_div",   1, DIV, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFD, 65, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
